// File: rtl/masked_subbytes_sequencer.sv
// Byte-serial SubBytes sequencer in front of a pipelined masked S-box.
// Latency: out_valid rises 16+SBOX_LATENCY cycles after the accept edge.
// Backpressure: one state in flight; out_ready low in RUN/DONE, DONE holds until in_ready.
//
// Ports:
//   in_clock, in_reset      rising-edge clock, synchronous active-low reset
//   in_state/in_enc/in_valid, out_ready   shared state input handshake
//   out_sbox_a, out_sbox_enc, in_sbox_b   initiator side of the S-box pipeline
//   out_state/out_valid, in_ready         substituted shared state handshake
module masked_subbytes_sequencer #(
  parameter int NUM_SHARES   = 2,
  parameter int SBOX_LATENCY = 3
) (
  input  logic                      in_clock,
  input  logic                      in_reset,
  input  logic [128*NUM_SHARES-1:0] in_state,
  input  logic                      in_enc,
  input  logic                      in_valid,
  output logic                      out_ready,
  output logic [8*NUM_SHARES-1:0]   out_sbox_a,
  output logic                      out_sbox_enc,
  input  logic [8*NUM_SHARES-1:0]   in_sbox_b,
  output logic [128*NUM_SHARES-1:0] out_state,
  output logic                      out_valid,
  input  logic                      in_ready
);

  localparam int CW = $clog2(16 + SBOX_LATENCY);
  localparam logic [CW-1:0] C_LAT    = CW'(SBOX_LATENCY);
  localparam logic [CW-1:0] C_LAST   = CW'(15 + SBOX_LATENCY);
  localparam logic [CW-1:0] C_NBYTES = CW'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_nxt;
  logic [128*NUM_SHARES-1:0] r_in_state;
  logic                      r_enc;
  logic [128*NUM_SHARES-1:0] r_out_state;

  logic                      w_accept;
  logic                      w_issue_en;
  logic                      w_collect_en;
  logic [3:0]                w_issue_idx;
  logic [3:0]                w_collect_idx;

  assign w_accept      = (r_state == IDLE) && in_valid;
  assign w_issue_en    = (r_state == RUN) && (r_cnt < C_NBYTES);
  assign w_collect_en  = (r_state == RUN) && (r_cnt >= C_LAT);
  assign w_issue_idx   = r_cnt[3:0];
  // The S-box returns byte k exactly SBOX_LATENCY cycles after it was issued.
  assign w_collect_idx = 4'(r_cnt - C_LAT);

  // FSM state register
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (r_cnt == C_LAST) begin
          // Park the counter at zero so DONE never depends on wrap behaviour.
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      DONE: begin
        if (in_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Datapath: each share lives in its own slice; nothing ever crosses shares.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      r_in_state  <= '0;
      r_enc       <= 1'b0;
      r_out_state <= '0;
    end else begin
      if (w_accept) begin
        r_in_state <= in_state;
        r_enc      <= in_enc;
      end
      if (w_collect_en) begin
        for (int s = 0; s < NUM_SHARES; s++) begin
          r_out_state[128*s + 8*w_collect_idx +: 8] <= in_sbox_b[8*s +: 8];
        end
      end
    end
  end

  // Per-share issue mux, selected only by the counter.
  for (genvar gs = 0; gs < NUM_SHARES; gs++) begin : g_share
    assign out_sbox_a[8*gs +: 8] = w_issue_en ? r_in_state[128*gs + 8*w_issue_idx +: 8] : 8'h00;
  end

  assign out_sbox_enc = (r_state == RUN) && r_enc;
  assign out_ready    = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign out_state    = r_out_state;

endmodule

// File: tb/tb_masked_subbytes_sequencer.sv
// Scoreboard bench for masked_subbytes_sequencer: two instances (2 shares/latency 3,
// 3 shares/latency 5), each driving a behavioural pipelined masked S-box model.
module tb_masked_subbytes_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: 2 shares, latency 3
  logic [255:0] a_in_state;
  logic         a_in_enc, a_in_valid, a_out_ready, a_sbox_enc, a_out_valid, a_in_ready;
  logic [15:0]  a_sbox_a, a_sbox_b;
  logic [255:0] a_out_state;

  masked_subbytes_sequencer #(.NUM_SHARES(2), .SBOX_LATENCY(3)) u_dut_a (
    .in_clock(clk), .in_reset(rst_n), .in_state(a_in_state), .in_enc(a_in_enc),
    .in_valid(a_in_valid), .out_ready(a_out_ready), .out_sbox_a(a_sbox_a),
    .out_sbox_enc(a_sbox_enc), .in_sbox_b(a_sbox_b), .out_state(a_out_state),
    .out_valid(a_out_valid), .in_ready(a_in_ready)
  );

  // Instance B: 3 shares, latency 5
  logic [383:0] b_in_state;
  logic         b_in_enc, b_in_valid, b_out_ready, b_sbox_enc, b_out_valid, b_in_ready;
  logic [23:0]  b_sbox_a, b_sbox_b;
  logic [383:0] b_out_state;

  masked_subbytes_sequencer #(.NUM_SHARES(3), .SBOX_LATENCY(5)) u_dut_b (
    .in_clock(clk), .in_reset(rst_n), .in_state(b_in_state), .in_enc(b_in_enc),
    .in_valid(b_in_valid), .out_ready(b_out_ready), .out_sbox_a(b_sbox_a),
    .out_sbox_enc(b_sbox_enc), .in_sbox_b(b_sbox_b), .out_state(b_out_state),
    .out_valid(b_out_valid), .in_ready(b_in_ready)
  );

  // AES tables built from GF(2^8) inversion plus the affine map.
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  // Masked S-box share mapping: shares 1.. are remasked by a fixed per-share
  // rotation/constant; share 0 absorbs the S-box output of the recombined byte.
  function automatic logic [23:0] sbox_model(input logic [23:0] a, input int ns, input logic enc);
    logic [7:0]  u, o0, t;
    logic [23:0] r;
    u = 8'h00;
    r = 24'h0;
    for (int s = 0; s < ns; s++) u = u ^ a[8*s +: 8];
    o0 = enc ? sbox_t[u] : isbox_t[u];
    for (int s = 1; s < ns; s++) begin
      t = a[8*s +: 8];
      r[8*s +: 8] = {t[6:0], t[7]} ^ (8'h5A + 8'(s));
      o0 = o0 ^ r[8*s +: 8];
    end
    r[7:0] = o0;
    return r;
  endfunction

  function automatic logic [383:0] expect_state(input logic [383:0] st, input int ns, input logic enc);
    logic [383:0] r;
    logic [23:0]  a, b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      a = 24'h0;
      for (int s = 0; s < ns; s++) a[8*s +: 8] = st[128*s + 8*i +: 8];
      b = sbox_model(a, ns, enc);
      for (int s = 0; s < ns; s++) r[128*s + 8*i +: 8] = b[8*s +: 8];
    end
    return r;
  endfunction

  // Free-running S-box pipelines
  logic [15:0] pa [3];
  logic [23:0] pb [5];
  always @(posedge clk) begin
    pa[0] <= 16'(sbox_model({8'h00, a_sbox_a}, 2, a_sbox_enc));
    for (int i = 1; i < 3; i++) pa[i] <= pa[i-1];
    pb[0] <= sbox_model(b_sbox_a, 3, b_sbox_enc);
    for (int i = 1; i < 5; i++) pb[i] <= pb[i-1];
  end
  assign a_sbox_b = pa[2];
  assign b_sbox_b = pb[4];

  typedef struct packed {
    logic [383:0] exp;
    logic [31:0]  acc;
    logic [127:0] hval;
    logic [127:0] hmask;
  } sb_t;
  sb_t qa[$];
  sb_t qb[$];

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no DUT event within bound, required one", name);
  endtask

  // Monitors: pop and compare on each rising out_valid.
  logic a_prev_v = 1'b0;
  sb_t  ea;
  always @(posedge clk) begin
    #1;
    if (a_out_valid && !a_prev_v) begin
      if (qa.size() == 0) timeout_fail("a_unexpected_valid");
      else begin
        ea = qa.pop_front();
        chk("a_state", {128'b0, a_out_state}, ea.exp);
        chk_int("a_latency", cyc - int'(ea.acc), 19);
        chk("a_hand", {256'b0, (a_out_state[127:0] ^ a_out_state[255:128]) & ea.hmask},
            {256'b0, ea.hval & ea.hmask});
        chk_int("a_ready_in_done", int'(a_out_ready), 0);
        chk_int("a_sbox_a_in_done", int'(a_sbox_a), 0);
      end
    end
    a_prev_v = a_out_valid;
  end

  logic b_prev_v = 1'b0;
  sb_t  eb;
  always @(posedge clk) begin
    #1;
    if (b_out_valid && !b_prev_v) begin
      if (qb.size() == 0) timeout_fail("b_unexpected_valid");
      else begin
        eb = qb.pop_front();
        chk("b_state", b_out_state, eb.exp);
        chk_int("b_latency", cyc - int'(eb.acc), 21);
        chk("b_hand", {256'b0, (b_out_state[127:0] ^ b_out_state[255:128] ^ b_out_state[383:256]) & eb.hmask},
            {256'b0, eb.hval & eb.hmask});
      end
    end
    b_prev_v = b_out_valid;
  end

  task automatic a_send(input logic [255:0] st, input logic enc, input logic [127:0] hv,
                        input logic [127:0] hm, input logic keep, input logic [255:0] alt);
    int  n;
    sb_t e;
    n = 0;
    while (!a_out_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!a_out_ready) timeout_fail("a_ready_wait");
    a_in_state = st;
    a_in_enc   = enc;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    e.exp   = expect_state({128'b0, st}, 2, enc);
    e.acc   = 32'(cyc);
    e.hval  = hv;
    e.hmask = hm;
    qa.push_back(e);
    if (keep) a_in_state = alt;
    else a_in_valid = 1'b0;
  endtask

  task automatic a_wait_done(input int hold, input logic enc, input logic rdy_run);
    int           n;
    int           bad;
    logic [255:0] snap;
    n   = 0;
    bad = 0;
    a_in_ready = rdy_run;
    while (!a_out_valid && n < 60) begin
      if (a_out_ready || (a_sbox_enc !== enc)) bad = 1;
      @(posedge clk); #1;
      n++;
    end
    if (!a_out_valid) timeout_fail("a_valid_wait");
    chk_int("a_run_ctrl", bad, 0);
    if (hold > 0) a_in_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      snap = a_out_state;
      @(posedge clk); #1;
      if ((a_out_state !== snap) || !a_out_valid || a_out_ready) bad = 1;
    end
    chk_int("a_done_hold", bad, 0);
    a_in_ready = 1'b1;
    @(posedge clk); #1;
    a_in_ready = 1'b0;
    chk_int("a_valid_drop", int'(a_out_valid), 0);
    chk_int("a_ready_rise", int'(a_out_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish within bound");
    $fatal(1, "watchdog");
  end

  logic [127:0] u, u2, r1, r2, hv, hm;
  int           n;
  sb_t          e;

  initial begin
    build_tables();
    rst_n = 1'b0;
    a_in_state = '0; a_in_enc = 1'b0; a_in_valid = 1'b0; a_in_ready = 1'b0;
    b_in_state = '0; b_in_enc = 1'b0; b_in_valid = 1'b0; b_in_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk_int("rst_a_valid", int'(a_out_valid), 0);
    chk_int("rst_a_ready", int'(a_out_ready), 1);
    chk_int("rst_a_sbox_a", int'(a_sbox_a), 0);
    chk_int("rst_a_sbox_enc", int'(a_sbox_enc), 0);
    chk("rst_a_state", {128'b0, a_out_state}, 384'b0);
    chk_int("rst_b_ready", int'(b_out_ready), 1);
    chk("rst_b_state", b_out_state, 384'b0);

    // Forward, byte i = i
    for (int i = 0; i < 16; i++) u[8*i +: 8] = 8'(i);
    r1 = {$urandom, $urandom, $urandom, $urandom};
    hv = '0; hm = '0;
    hv[7:0] = 8'h63; hv[15:8] = 8'h7C; hv[23:16] = 8'h77; hv[127:120] = 8'h76;
    hm[23:0] = 24'hFFFFFF; hm[127:120] = 8'hFF;
    a_send({r1, u ^ r1}, 1'b1, hv, hm, 1'b0, 256'b0);
    a_wait_done(0, 1'b1, 1'b0);

    // Inverse, all 0x63 -> all 0x00; in_ready high during RUN has no effect
    u  = {16{8'h63}};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    a_send({r1, u ^ r1}, 1'b0, 128'b0, {128{1'b1}}, 1'b0, 256'b0);
    a_wait_done(0, 1'b0, 1'b1);

    // DONE hold with in_valid held high carrying another state; that state is
    // then accepted back-to-back right after the handshake.
    u  = {16{8'h53}};
    u2 = {16{8'h00}};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    a_send({r1, u ^ r1}, 1'b1, {16{8'hED}}, {128{1'b1}}, 1'b1, {r2, u2 ^ r2});
    a_wait_done(10, 1'b1, 1'b0);
    a_send({r2, u2 ^ r2}, 1'b1, {16{8'h63}}, {128{1'b1}}, 1'b0, 256'b0);
    a_wait_done(0, 1'b1, 1'b0);

    // Reset mid-run at cnt=8
    u  = {$urandom, $urandom, $urandom, $urandom};
    r1 = {$urandom, $urandom, $urandom, $urandom};
    a_send({r1, u ^ r1}, 1'b1, 128'b0, 128'b0, 1'b0, 256'b0);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(qa.pop_back());
    chk_int("midrst_valid", int'(a_out_valid), 0);
    chk_int("midrst_ready", int'(a_out_ready), 1);
    chk_int("midrst_sbox_a", int'(a_sbox_a), 0);
    chk_int("midrst_sbox_enc", int'(a_sbox_enc), 0);
    u  = {$urandom, $urandom, $urandom, $urandom};
    u[7:0] = 8'h53;
    r1 = {$urandom, $urandom, $urandom, $urandom};
    hv = '0; hv[7:0] = 8'hED;
    hm = '0; hm[7:0] = 8'hFF;
    a_send({r1, u ^ r1}, 1'b1, hv, hm, 1'b0, 256'b0);
    a_wait_done(0, 1'b1, 1'b0);

    // Three shares, latency 5
    for (int i = 0; i < 16; i++) u[8*i +: 8] = 8'(i);
    r1 = {$urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (!b_out_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!b_out_ready) timeout_fail("b_ready_wait");
    b_in_state = {r2, r1, u ^ r1 ^ r2};
    b_in_enc   = 1'b1;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    e.exp   = expect_state({r2, r1, u ^ r1 ^ r2}, 3, 1'b1);
    e.acc   = 32'(cyc);
    e.hval  = '0; e.hval[7:0] = 8'h63; e.hval[127:120] = 8'h76;
    e.hmask = '0; e.hmask[7:0] = 8'hFF; e.hmask[127:120] = 8'hFF;
    qb.push_back(e);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!b_out_valid) timeout_fail("b_valid_wait");
    b_in_ready = 1'b1;
    @(posedge clk); #1;
    b_in_ready = 1'b0;
    chk_int("b_valid_drop", int'(b_out_valid), 0);
    chk_int("b_ready_rise", int'(b_out_ready), 1);

    repeat (3) @(posedge clk);
    #2;
    chk_int("a_sb_empty", qa.size(), 0);
    chk_int("b_sb_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
